// File: rtl/mestpro_mem_pipe.sv
// MESTPro single-port RAM: byte enables, zero-fill sweep after reset, RD_LAT-cycle pipelined reads.
// Optional per-byte even parity with error flag and injection input when MESTPRO_MEM_PARITY_EN is defined.
module mestpro_mem_pipe #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CS,
  input  logic                   WE,
  input  logic [DATA_BITS/8-1:0] BE,
  input  logic [ADDR_BITS-1:0]   addr,
  input  logic [DATA_BITS-1:0]   in_dat,
  output logic                   ready,
  output logic [DATA_BITS-1:0]   o_dat,
  output logic                   o_valid,
  output logic                   init_done
`ifdef MESTPRO_MEM_PARITY_EN
  ,
  input  logic                   par_inj,
  output logic                   par_err
`endif
);

  localparam int NB    = DATA_BITS / 8;
  localparam int DEPTH = 2 ** ADDR_BITS;

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("mestpro_mem_pipe: RD_LAT must be in 1..3");
  end
  if (DATA_BITS % 8 != 0) begin : g_bad_data_bits
    $error("mestpro_mem_pipe: DATA_BITS must be a multiple of 8");
  end

  typedef enum logic {INIT, IDLE} state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   init_cnt;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic                   sweep_we;
  logic                   acc;
  logic                   rd_acc;
  logic                   wr_acc;
  logic                   vld_p0, vld_p1, vld_p2;
  logic signed [DATA_BITS-1:0] dat_p0, dat_p1, dat_p2;
  logic                   src_vld;
  logic [DATA_BITS-1:0]   src_dat;

  assign sweep_we = RESET && (state == INIT);
  assign acc      = CS && ready;
  assign rd_acc   = acc && !WE;
  assign wr_acc   = acc && WE;

`ifdef MESTPRO_MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          perr_p0, perr_p1, perr_p2;
  logic          src_perr;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_BITS-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= INIT;
      init_cnt  <= '0;
      ready     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == {ADDR_BITS{1'b1}}) begin
            state     <= IDLE;
            ready     <= 1'b1;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          ready     <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Array write port: zero sweep has priority, otherwise byte-masked request writes
  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      mem[init_cnt] <= '0;
`ifdef MESTPRO_MEM_PARITY_EN
      par_mem[init_cnt] <= '0;
`endif
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (BE[i]) begin
          mem[addr][8*i +: 8] <= in_dat[8*i +: 8];
`ifdef MESTPRO_MEM_PARITY_EN
          par_mem[addr][i] <= (^in_dat[8*i +: 8]) ^ (i == 0 && par_inj);
`endif
        end
      end
    end
  end

  // Stage p0: array read; p1/p2 extend the pipe for longer latencies
  always_ff @(posedge CLK) begin
    dat_p0 <= mem[addr];
    dat_p1 <= dat_p0;
    dat_p2 <= dat_p1;
`ifdef MESTPRO_MEM_PARITY_EN
    perr_p0 <= |(byte_par(mem[addr]) ^ par_mem[addr]);
    perr_p1 <= perr_p0;
    perr_p2 <= perr_p1;
`endif
  end

  always_comb begin
    src_vld = vld_p0;
    src_dat = dat_p0;
`ifdef MESTPRO_MEM_PARITY_EN
    src_perr = perr_p0;
`endif
    if (RD_LAT == 2) begin
      src_vld = vld_p1;
      src_dat = dat_p1;
`ifdef MESTPRO_MEM_PARITY_EN
      src_perr = perr_p1;
`endif
    end else if (RD_LAT == 3) begin
      src_vld = vld_p2;
      src_dat = dat_p2;
`ifdef MESTPRO_MEM_PARITY_EN
      src_perr = perr_p2;
`endif
    end
  end

  // Output stage: o_dat only reloads on a valid result so it holds between reads
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      o_valid <= 1'b0;
      o_dat   <= '0;
`ifdef MESTPRO_MEM_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      vld_p0  <= rd_acc;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      o_valid <= src_vld;
      if (src_vld) o_dat <= src_dat;
`ifdef MESTPRO_MEM_PARITY_EN
      par_err <= src_vld && src_perr;
`endif
    end
  end

endmodule

// File: doc/mestpro_mem_pipe.md
Name: mestpro_mem_pipe

Overview:
- Parametrised successor to the MESTPro single-port memory: synchronous RAM with per-byte write enables, configurable read latency and a ready/valid request handshake.
- Self-initialising: after reset it sweeps every location to zero before accepting requests.
- Sits behind the MESTPro core's load/store path, and the top-level memory stimulus bench drives it directly.

Parameters:
- DATA_BITS, 32, word width; must be a multiple of 8.
- ADDR_BITS, 8, address width; depth = 2**ADDR_BITS words.
- RD_LAT, 1, read latency in cycles, legal 1..3; any other value fails elaboration.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous reset, active-low.
- CS  in  1  request valid.
- WE  in  1  1=write, 0=read; sampled with CS.
- BE  in  DATA_BITS/8  byte write enables; bit i covers in_dat[8i+7:8i].
- addr  in  ADDR_BITS  word address.
- in_dat  in  DATA_BITS  write data.
- ready  out  1  block can accept a request this cycle.
- o_dat  out  DATA_BITS  read data.
- o_valid  out  1  o_dat carries a new read result this cycle.
- init_done  out  1  zero-fill sweep complete.

Behaviour:
- Reset (RESET=0, asynchronous): ready=0, o_valid=0, o_dat=0, init_done=0, read pipeline cleared, FSM=INIT, init counter=0. RAM array is not reset directly.
- FSM states and transitions:
  - INIT: one zero word per cycle written to address init_cnt, starting the first edge after RESET rises.
  - INIT→IDLE after writing address 2**ADDR_BITS-1. The sweep takes exactly 2**ADDR_BITS cycles.
  - IDLE: ready=1 and init_done=1 from the following cycle, held until the next reset.
- Acceptance: request accepted at a rising edge with CS=1 and ready=1. CS while ready=0 is ignored, with no side effects.
- Write:
  - Only bytes with BE[i]=1 are updated.
  - BE all-zero: accepted, no-op.
  - No o_valid is produced.
- Read:
  - Accepted at edge N → o_dat valid and o_valid=1 for exactly one cycle after edge N+RD_LAT.
  - Fully pipelined: one read per cycle, results returned in order.
  - o_dat holds the last read value while o_valid=0.
- Single port: one operation per cycle.
- Read accepted at edge N+1 to an address written at edge N returns the new data.
- Read data is independent of BE.
- All 2**ADDR_BITS addresses are valid; there is no out-of-range case.
- Reset mid-operation (reads in flight or sweep in progress): in-flight reads are dropped with no o_valid, and the full zero sweep restarts after RESET rises.

Optional Feature:
- Macro: MESTPRO_MEM_PARITY_EN.
- Defined:
  - Each byte stores an even-parity bit, written under BE together with its data byte. The sweep stores parity 0.
  - Extra output par_err (1 bit) pulses with o_valid when any byte of the read word has a parity mismatch. Reset value 0.
  - Extra input par_inj (1 bit): when 1 on an accepted write, byte 0 parity is stored inverted.
- Undefined: no parity storage; par_err and par_inj ports do not exist. Behaviour is otherwise identical.

Test Plan:
- Release RESET with ADDR_BITS=4, RD_LAT=1 → ready=0 for exactly 16 cycles, then ready=1 and init_done=1; reads of addr 0..15 return 0x00000000.
- Write 0xDEADBEEF to 0x05 with BE=4'b1111, then write 0x11223344 to 0x05 with BE=4'b0101, then read 0x05 → o_dat=0xDE22BE44.
- RD_LAT=3: back-to-back reads of 0x01, 0x02, 0x03 at edges N..N+2 → o_valid high after edges N+3, N+4, N+5 with the matching data in order.
- Write 0xA5A5A5A5 to 0x0A at edge N, read 0x0A at edge N+1 → 0xA5A5A5A5; CS=1 asserted during INIT → no write occurs (location reads 0 afterwards).
- Assert RESET while a read is in flight → no o_valid pulse, o_dat=0, and the 2**ADDR_BITS-cycle zero sweep repeats.
- MESTPRO_MEM_PARITY_EN: write 0x000000FF with par_inj=1, then read → par_err=1 with o_valid. Same write with par_inj=0 → par_err=0.
